// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: bundles the two requester buses and the shared BRAM port
// of ram_port_arbiter. The slave modport is the arbiter. The master modport is its environment,
// which holds both requesters and the RAM.
interface ram_port_arbiter_if #(
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned ADDRESS_WIDTH = 8
);
   // Requester 0
   logic                     req_0;
   logic                     we_0;
   logic [ADDRESS_WIDTH-1:0] addr_0;
   logic [DATA_WIDTH-1:0]    wdata_0;
   logic                     gnt_0;
   logic                     rvalid_0;
   logic [DATA_WIDTH-1:0]    rdata_0;
   // Requester 1
   logic                     req_1;
   logic                     we_1;
   logic [ADDRESS_WIDTH-1:0] addr_1;
   logic [DATA_WIDTH-1:0]    wdata_1;
   logic                     gnt_1;
   logic                     rvalid_1;
   logic [DATA_WIDTH-1:0]    rdata_1;
   // Shared RAM port
   logic                     ram_cs;
   logic                     ram_we;
   logic                     ram_oe;
   logic [ADDRESS_WIDTH-1:0] ram_address;
   logic [DATA_WIDTH-1:0]    ram_din;
   logic [DATA_WIDTH-1:0]    ram_dout;

   modport slave (
      input  req_0, we_0, addr_0, wdata_0,
      input  req_1, we_1, addr_1, wdata_1,
      input  ram_dout,
      output gnt_0, rvalid_0, rdata_0,
      output gnt_1, rvalid_1, rdata_1,
      output ram_cs, ram_we, ram_oe, ram_address, ram_din
   );

   modport master (
      output req_0, we_0, addr_0, wdata_0,
      output req_1, we_1, addr_1, wdata_1,
      output ram_dout,
      input  gnt_0, rvalid_0, rdata_0,
      input  gnt_1, rvalid_1, rdata_1,
      input  ram_cs, ram_we, ram_oe, ram_address, ram_din
   );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: two requesters share one synchronous BRAM port.
// The grant is Mealy, so beats from one owner follow each other without a bubble.
// By default it arbitrates round-robin and limits each owner to MAX_BURST consecutive beats.
// Define ARB_FIXED_PRIO_EN to switch to strict priority: port 0 always wins.
// The RAM command is registered, and read data returns two cycles after the grant.
module ram_port_arbiter #(
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned ADDRESS_WIDTH = 8,
   parameter int unsigned MAX_BURST     = 4
) (
   input logic               clk,
   input logic               rst,
   ram_port_arbiter_if.slave bus
);
   typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

   state_e                   state_q, state_d;
   logic                     rr_q, rr_d;              // port granted most recently
   logic [7:0]               burst_cnt_q, burst_cnt_d;
   logic                     gnt_0, gnt_1, gnt_any;
   logic                     we_sel;
   logic [ADDRESS_WIDTH-1:0] addr_sel;
   logic [DATA_WIDTH-1:0]    wdata_sel;

   logic                     ram_cs_q, ram_we_q, ram_oe_q;
   logic [ADDRESS_WIDTH-1:0] ram_address_q;
   logic [DATA_WIDTH-1:0]    ram_din_q;

   // Read tag pipe: stage 1 lines up with the RAM command, stage 2 with ram_dout
   logic                     tag1_vld_q, tag1_own_q, tag2_vld_q, tag2_own_q;

`ifndef ARB_FIXED_PRIO_EN
   logic burst_ok;
   assign burst_ok = 32'(burst_cnt_q) < (MAX_BURST - 1);
`endif

   // Grant decision and next state
   always_comb begin
      gnt_0       = 1'b0;
      gnt_1       = 1'b0;
      burst_cnt_d = burst_cnt_q;
`ifdef ARB_FIXED_PRIO_EN
      gnt_0 = bus.req_0;
      gnt_1 = bus.req_1 & ~bus.req_0;
`else
      unique case (state_q)
         StOwn0: begin
            if (bus.req_0 && (burst_ok || !bus.req_1)) begin
               gnt_0 = 1'b1;
               if (burst_cnt_q != 8'hFF) burst_cnt_d = burst_cnt_q + 8'd1;
            end else begin
               gnt_1       = bus.req_1;
               burst_cnt_d = '0;
            end
         end
         StOwn1: begin
            if (bus.req_1 && (burst_ok || !bus.req_0)) begin
               gnt_1 = 1'b1;
               if (burst_cnt_q != 8'hFF) burst_cnt_d = burst_cnt_q + 8'd1;
            end else begin
               gnt_0       = bus.req_0;
               burst_cnt_d = '0;
            end
         end
         default: begin
            burst_cnt_d = '0;
            if (bus.req_0 && bus.req_1) begin
               // Tie goes to the port that was not granted last
               gnt_0 = rr_q;
               gnt_1 = ~rr_q;
            end else begin
               gnt_0 = bus.req_0;
               gnt_1 = bus.req_1;
            end
         end
      endcase
`endif
      if (rst) begin
         gnt_0 = 1'b0;
         gnt_1 = 1'b0;
      end
      state_d = gnt_0 ? StOwn0 : (gnt_1 ? StOwn1 : StIdle);
      rr_d    = gnt_0 ? 1'b0 : (gnt_1 ? 1'b1 : rr_q);
   end

   assign gnt_any   = gnt_0 | gnt_1;
   assign we_sel    = gnt_0 ? bus.we_0    : bus.we_1;
   assign addr_sel  = gnt_0 ? bus.addr_0  : bus.addr_1;
   assign wdata_sel = gnt_0 ? bus.wdata_0 : bus.wdata_1;

   // Arbiter state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         rr_q        <= 1'b1;
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

   // Registered RAM command; address and data hold while idle
   always_ff @(posedge clk) begin
      if (rst) begin
         ram_cs_q      <= 1'b0;
         ram_we_q      <= 1'b0;
         ram_oe_q      <= 1'b0;
         ram_address_q <= '0;
         ram_din_q     <= '0;
      end else begin
         ram_cs_q <= gnt_any;
         ram_we_q <= gnt_any & we_sel;
         ram_oe_q <= gnt_any & ~we_sel;
         if (gnt_any) begin
            ram_address_q <= addr_sel;
            ram_din_q     <= wdata_sel;
         end
      end
   end

   // Owner tags for reads in flight; reset drops them
   always_ff @(posedge clk) begin
      if (rst) begin
         tag1_vld_q <= 1'b0;
         tag1_own_q <= 1'b0;
         tag2_vld_q <= 1'b0;
         tag2_own_q <= 1'b0;
      end else begin
         tag1_vld_q <= gnt_any & ~we_sel;
         tag1_own_q <= gnt_1;
         tag2_vld_q <= tag1_vld_q;
         tag2_own_q <= tag1_own_q;
      end
   end

   assign bus.gnt_0       = gnt_0;
   assign bus.gnt_1       = gnt_1;
   assign bus.rvalid_0    = tag2_vld_q & ~tag2_own_q;
   assign bus.rvalid_1    = tag2_vld_q & tag2_own_q;
   assign bus.rdata_0     = bus.ram_dout;
   assign bus.rdata_1     = bus.ram_dout;
   assign bus.ram_cs      = ram_cs_q;
   assign bus.ram_we      = ram_we_q;
   assign bus.ram_oe      = ram_oe_q;
   assign bus.ram_address = ram_address_q;
   assign bus.ram_din     = ram_din_q;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed bench for ram_port_arbiter with a behavioural BRAM.
// Build with +define+ARB_FIXED_PRIO_EN to exercise the strict-priority variant.
module tb_ram_port_arbiter;
   localparam int unsigned DW = 8;
   localparam int unsigned AW = 8;

   logic   clk = 1'b0;
   logic   rst = 1'b1;
   int     n_cmp = 0;
   int     n_err = 0;
   logic [DW-1:0] mem [2**AW];

   ram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

   ram_port_arbiter #(
      .DATA_WIDTH   (DW),
      .ADDRESS_WIDTH(AW),
      .MAX_BURST    (4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Behavioural synchronous BRAM: dout valid the cycle after the read command
   always @(posedge clk) begin
      if (bus.ram_cs && bus.ram_we) mem[bus.ram_address] <= bus.ram_din;
      if (bus.ram_cs && bus.ram_oe) bus.ram_dout <= mem[bus.ram_address];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drop_reqs();
      bus.req_0 = 1'b0;
      bus.req_1 = 1'b0;
      bus.we_0  = 1'b0;
      bus.we_1  = 1'b0;
   endtask

   task automatic test_reset();
      logic [4:0] obs;
      bus.req_0 = 1'b1;
      bus.req_1 = 1'b1;
      rst       = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         obs = {bus.gnt_0, bus.gnt_1, bus.rvalid_0, bus.rvalid_1, bus.ram_cs};
         n_cmp++;
         if (obs !== 5'b0) begin
            n_err++;
            $display("FAIL reset_outputs c%0d: got %b expected 00000", c, obs);
         end
      end
      tick();
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({bus.gnt_0, bus.gnt_1} !== 2'b10) begin
         n_err++;
         $display("FAIL first_grant: got %b expected 10", {bus.gnt_0, bus.gnt_1});
      end
      tick();
      drop_reqs();
      @(negedge clk);
      n_cmp++;
      if ({bus.ram_cs, bus.ram_we, bus.ram_oe} !== 3'b101) begin
         n_err++;
         $display("FAIL first_cmd cs/we/oe: got %b expected 101",
                  {bus.ram_cs, bus.ram_we, bus.ram_oe});
      end
      repeat (3) tick();
   endtask

   task automatic test_write_read();
      logic [DW-1:0] wv [3];
      wv[0] = 8'd145;
      wv[1] = 8'd155;
      wv[2] = 8'd165;
      for (int k = 0; k < 9; k++) begin
         tick();
         if (k < 6) begin
            bus.req_0   = 1'b1;
            bus.we_0    = (k < 3);
            bus.addr_0  = AW'(k % 3);
            bus.wdata_0 = wv[k % 3];
         end else begin
            drop_reqs();
         end
         @(negedge clk);
         n_cmp++;
         if (bus.gnt_0 !== (k < 6) || bus.gnt_1 !== 1'b0) begin
            n_err++;
            $display("FAIL wr_rd_gnt k%0d: got %b%b expected %b0", k, bus.gnt_0, bus.gnt_1, k < 6);
         end
         n_cmp++;
         if (bus.rvalid_0 !== (k >= 5 && k <= 7) || bus.rvalid_1 !== 1'b0) begin
            n_err++;
            $display("FAIL wr_rd_rvalid k%0d: got %b%b expected %b0", k, bus.rvalid_0,
                     bus.rvalid_1, k >= 5 && k <= 7);
         end
         if (k >= 5 && k <= 7) begin
            n_cmp++;
            if (bus.rdata_0 !== wv[k-5]) begin
               n_err++;
               $display("FAIL wr_rd_rdata k%0d: got %0d expected %0d", k, bus.rdata_0, wv[k-5]);
            end
         end
         if (k == 1) begin
            n_cmp++;
            if ({bus.ram_cs, bus.ram_we, bus.ram_oe} !== 3'b110 || bus.ram_address !== 8'd0 ||
                bus.ram_din !== 8'd145) begin
               n_err++;
               $display("FAIL wr_cmd: got cs/we/oe %b addr %0d din %0d expected 110 0 145",
                        {bus.ram_cs, bus.ram_we, bus.ram_oe}, bus.ram_address, bus.ram_din);
            end
         end
      end
      repeat (3) tick();
   endtask

`ifdef ARB_FIXED_PRIO_EN
   task automatic test_fixed_prio();
      tick();
      rst = 1'b1;
      tick();
      rst       = 1'b0;
      bus.req_0 = 1'b1;
      bus.req_1 = 1'b1;
      bus.addr_0 = 8'd0;
      bus.addr_1 = 8'd1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         n_cmp++;
         if ({bus.gnt_0, bus.gnt_1} !== 2'b10) begin
            n_err++;
            $display("FAIL fixed_prio k%0d: got %b expected 10", k, {bus.gnt_0, bus.gnt_1});
         end
         tick();
      end
      drop_reqs();
      repeat (3) tick();
   endtask
`else
   task automatic test_round_robin();
      int unsigned own;
      int unsigned prev;
      tick();
      rst = 1'b1;
      tick();
      rst        = 1'b0;
      bus.req_0  = 1'b1;
      bus.req_1  = 1'b1;
      bus.we_0   = 1'b0;
      bus.we_1   = 1'b0;
      bus.addr_0 = 8'd0;
      bus.addr_1 = 8'd1;
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         own = (k < 12) ? (k / 4) % 2 : 2;
         n_cmp++;
         if (bus.gnt_0 !== (own == 0) || bus.gnt_1 !== (own == 1)) begin
            n_err++;
            $display("FAIL rr_gnt k%0d: got %b%b expected owner %0d", k, bus.gnt_0, bus.gnt_1,
                     own);
         end
         if (k >= 2) begin
            prev = ((k - 2) / 4) % 2;
            n_cmp++;
            if (bus.rvalid_0 !== (prev == 0) || bus.rvalid_1 !== (prev == 1)) begin
               n_err++;
               $display("FAIL rr_rvalid k%0d: got %b%b expected owner %0d", k, bus.rvalid_0,
                        bus.rvalid_1, prev);
            end
            n_cmp++;
            if (bus.ram_dout !== ((prev == 0) ? 8'd145 : 8'd155)) begin
               n_err++;
               $display("FAIL rr_rdata k%0d: got %0d expected %0d", k, bus.ram_dout,
                        (prev == 0) ? 145 : 155);
            end
         end
         tick();
         if (k == 11) drop_reqs();
      end
      repeat (3) tick();
   endtask
`endif

   task automatic test_write_forward();
      bus.req_1   = 1'b1;
      bus.we_1    = 1'b1;
      bus.addr_1  = 8'd3;
      bus.wdata_1 = 8'd175;
      @(negedge clk);
      n_cmp++;
      if ({bus.gnt_0, bus.gnt_1} !== 2'b01) begin
         n_err++;
         $display("FAIL fwd_wr_gnt: got %b expected 01", {bus.gnt_0, bus.gnt_1});
      end
      tick();
      drop_reqs();
      bus.req_0  = 1'b1;
      bus.addr_0 = 8'd3;
      @(negedge clk);
      n_cmp++;
      if ({bus.gnt_0, bus.gnt_1} !== 2'b10) begin
         n_err++;
         $display("FAIL fwd_rd_gnt: got %b expected 10", {bus.gnt_0, bus.gnt_1});
      end
      tick();
      drop_reqs();
      @(negedge clk);
      n_cmp++;
      if ({bus.rvalid_0, bus.rvalid_1} !== 2'b00) begin
         n_err++;
         $display("FAIL fwd_early: got %b expected 00", {bus.rvalid_0, bus.rvalid_1});
      end
      tick();
      @(negedge clk);
      n_cmp++;
      if ({bus.rvalid_0, bus.rvalid_1} !== 2'b10 || bus.rdata_0 !== 8'd175) begin
         n_err++;
         $display("FAIL fwd_read: got rvalid %b data %0d expected 10 175",
                  {bus.rvalid_0, bus.rvalid_1}, bus.rdata_0);
      end
      repeat (3) tick();
   endtask

   task automatic test_reset_mid();
      bus.req_0  = 1'b1;
      bus.we_0   = 1'b0;
      bus.addr_0 = 8'd2;
      @(negedge clk);
      n_cmp++;
      if (bus.gnt_0 !== 1'b1) begin
         n_err++;
         $display("FAIL midrst_gnt: got %b expected 1", bus.gnt_0);
      end
      tick();
      drop_reqs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({bus.rvalid_0, bus.rvalid_1, bus.ram_cs} !== 3'b000) begin
         n_err++;
         $display("FAIL midrst_drop: got rvalid/cs %b expected 000",
                  {bus.rvalid_0, bus.rvalid_1, bus.ram_cs});
      end
      tick();
      bus.req_0 = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({bus.gnt_0, bus.rvalid_0} !== 2'b10) begin
         n_err++;
         $display("FAIL midrst_reissue: got gnt/rvalid %b expected 10", {bus.gnt_0, bus.rvalid_0});
      end
      tick();
      drop_reqs();
      tick();
      @(negedge clk);
      n_cmp++;
      if (bus.rvalid_0 !== 1'b1 || bus.rdata_0 !== 8'd165) begin
         n_err++;
         $display("FAIL midrst_read: got rvalid %b data %0d expected 1 165", bus.rvalid_0,
                  bus.rdata_0);
      end
      repeat (3) tick();
   endtask

   initial begin
      bus.req_0   = 1'b0;
      bus.req_1   = 1'b0;
      bus.we_0    = 1'b0;
      bus.we_1    = 1'b0;
      bus.addr_0  = '0;
      bus.addr_1  = '0;
      bus.wdata_0 = '0;
      bus.wdata_1 = '0;
      test_reset();
      test_write_read();
`ifdef ARB_FIXED_PRIO_EN
      test_fixed_prio();
`else
      test_round_robin();
`endif
      test_write_forward();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
